// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 stream steering: each input word is routed by in_switch
// into one of two independent output FIFOs, each with its own routed-word counter.
module demux1to2_stream #(
   parameter int SIZE  = 16,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SIZE-1:0]  in_data,
   input  logic             in_switch,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [SIZE-1:0]  out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [SIZE-1:0]  out2_data,
   output logic             out2_valid,
   input  logic             out2_ready,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [1:0]       full;
   logic [1:0]       vld;
   logic [1:0]       cons_ready;
   logic [SIZE-1:0]  head_all [2];
   logic [CNT_W-1:0] cnt_all  [2];

   // No full-bypass: a pop in the same cycle does not free a slot for the push.
   assign in_ready   = in_switch ? !full[1] : !full[0];
   assign cons_ready = {out2_ready, out1_ready};

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [SIZE-1:0]  mem [DEPTH];
      logic [PTR_W-1:0] wr_ptr;
      logic [PTR_W-1:0] rd_ptr;
      logic [PTR_W-1:0] rd_nxt;
      logic [OCC_W-1:0] occ;
      logic [OCC_W-1:0] occ_nxt;
      logic [SIZE-1:0]  head;
      logic [CNT_W-1:0] cnt;
      logic             push;
      logic             pop;

      assign full[p]     = (occ == OCC_W'(DEPTH));
      assign vld[p]      = (occ != '0);
      assign head_all[p] = head;
      assign cnt_all[p]  = cnt;
      assign push        = in_valid && in_ready && (in_switch == 1'(p));
      assign pop         = vld[p] && cons_ready[p];
      assign rd_nxt      = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
      assign occ_nxt     = occ + OCC_W'(push) - OCC_W'(pop);

      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            head   <= '0;
            cnt    <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= in_data;
               wr_ptr      <= wr_ptr + PTR_W'(1);
               cnt         <= cnt + CNT_W'(1);
            end
            rd_ptr <= rd_nxt;
            occ    <= occ_nxt;
            // Head register tracks the next head; it holds its value once the FIFO drains.
            if (occ_nxt != '0)
               head <= (push && (wr_ptr == rd_nxt)) ? in_data : mem[rd_nxt];
         end
      end
   end

   assign out1_data  = head_all[0];
   assign out2_data  = head_all[1];
   assign out1_valid = vld[0];
   assign out2_valid = vld[1];
   assign cnt1       = cnt_all[0];
   assign cnt2       = cnt_all[1];

endmodule

// File: tb/tb_demux1to2_stream.sv
// Bench for demux1to2_stream: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_demux1to2_stream;
   localparam int SIZE  = 16;
   localparam int DEPTH = 2;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [SIZE-1:0]  in_data = '0;
   logic             in_switch = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [SIZE-1:0]  out1_data, out2_data;
   logic             out1_valid, out2_valid;
   logic             out1_ready = 1'b0;
   logic             out2_ready = 1'b0;
   logic [CNT_W-1:0] cnt1, cnt2;

   always #5 clk = ~clk;

   demux1to2_stream #(.SIZE(SIZE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_switch(in_switch), .in_valid(in_valid), .in_ready(in_ready),
      .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
      .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
      .cnt1(cnt1), .cnt2(cnt2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one queue per port, state as of the next rising edge.
   logic [SIZE-1:0]  q1[$];
   logic [SIZE-1:0]  q2[$];
   logic [SIZE-1:0]  exp_d1 = '0, exp_d2 = '0;
   logic [CNT_W-1:0] exp_c1 = '0, exp_c2 = '0;
   bit               model_live = 0;

   always @(negedge clk) begin
      bit exp_rdy;
      exp_rdy = in_switch ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
      if (model_live) begin
         chk("in_ready", in_ready, exp_rdy);
         chk("out1_valid", out1_valid, q1.size() != 0);
         chk("out2_valid", out2_valid, q2.size() != 0);
         chk("out1_data", out1_data, exp_d1);
         chk("out2_data", out2_data, exp_d2);
         chk("cnt1", cnt1, exp_c1);
         chk("cnt2", cnt2, exp_c2);
      end
      if (rst) begin
         q1.delete();
         q2.delete();
         exp_d1 = '0; exp_d2 = '0; exp_c1 = '0; exp_c2 = '0;
         model_live = 1;
      end else begin
         if (q1.size() != 0 && out1_ready) void'(q1.pop_front());
         if (q2.size() != 0 && out2_ready) void'(q2.pop_front());
         if (in_valid && exp_rdy) begin
            if (in_switch) begin q2.push_back(in_data); exp_c2 = exp_c2 + 1'b1; end
            else           begin q1.push_back(in_data); exp_c1 = exp_c1 + 1'b1; end
         end
         if (q1.size() != 0) exp_d1 = q1[0];
         if (q2.size() != 0) exp_d2 = q2[0];
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic sw, input logic [SIZE-1:0] d);
      in_valid = v; in_switch = sw; in_data = d;
   endtask

   task automatic do_reset();
      drive(0, 0, '0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      bit stall;
      // Reset held for two cycles with in_valid high
      drive(1, 0, 16'hAAAA);
      cyc();
      in_switch = 1'b0; #1 chk("rst_ready_sw0", in_ready, 1);
      in_switch = 1'b1; #1 chk("rst_ready_sw1", in_ready, 1);
      cyc();
      rst = 1'b0;
      chk("rst_out1_valid", out1_valid, 0);
      chk("rst_out2_valid", out2_valid, 0);
      chk("rst_cnt1", cnt1, 0);
      chk("rst_cnt2", cnt2, 0);
      chk("rst_out1_data", out1_data, 0);
      drive(0, 0, '0);

      // Alternating routing
      out1_ready = 1; out2_ready = 1;
      drive(1, 0, 16'h1111); cyc();
      chk("alt_first_visible", out1_data, 16'h1111);
      drive(1, 1, 16'h2222); cyc();
      drive(1, 0, 16'h3333); cyc();
      drive(0, 0, '0);
      chk("alt_cnt1", cnt1, 2);
      chk("alt_cnt2", cnt2, 1);
      chk("alt_out1_data", out1_data, 16'h3333);
      chk("alt_out2_valid", out2_valid, 0);
      chk("alt_out2_hold", out2_data, 16'h2222);
      cyc();

      // Port-1 backpressure, port 2 keeps flowing
      out1_ready = 0; out2_ready = 1;
      drive(1, 0, 16'hA001); cyc();
      drive(1, 0, 16'hA002); cyc();
      drive(1, 0, 16'hA003); #1;
      chk("bp_in_ready_low", in_ready, 0);
      cyc();
      drive(1, 1, 16'hBEEF); #1;
      chk("bp_port2_ready", in_ready, 1);
      cyc();
      drive(0, 0, '0);
      chk("bp_port2_data", out2_data, 16'hBEEF);
      chk("bp_port1_head", out1_data, 16'hA001);
      out1_ready = 1;
      cyc();
      chk("bp_drain_second", out1_data, 16'hA002);
      repeat (3) cyc();

      // Full plus pop in the same cycle: no bypass
      out1_ready = 0;
      drive(1, 0, 16'hC001); cyc();
      drive(1, 0, 16'hC002); cyc();
      drive(1, 0, 16'hC003); out1_ready = 1; #1;
      chk("fp_ready_low", in_ready, 0);
      cyc();
      chk("fp_ready_next", in_ready, 1);
      cyc();
      drive(0, 0, '0);
      repeat (4) cyc();

      // Counter wrap on port 2
      do_reset();
      out1_ready = 1; out2_ready = 1;
      for (int i = 0; i < 256; i++) begin
         drive(1, 1, 16'(i * 7 + 3));
         cyc();
      end
      drive(0, 0, '0);
      chk("wrap_cnt2", cnt2, 0);
      chk("wrap_cnt1", cnt1, 0);
      cyc();

      // Mid-stream reset with two words queued per port
      out1_ready = 0; out2_ready = 0;
      drive(1, 0, 16'hD001); cyc();
      drive(1, 0, 16'hD002); cyc();
      drive(1, 1, 16'hE001); cyc();
      drive(1, 1, 16'hE002); cyc();
      drive(0, 0, '0);
      chk("mid_q_cnt1", cnt1, 2);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("mid_out1_valid", out1_valid, 0);
      chk("mid_out2_valid", out2_valid, 0);
      chk("mid_cnt1", cnt1, 0);
      chk("mid_cnt2", cnt2, 0);
      out1_ready = 1; out2_ready = 1;
      repeat (4) cyc();

      // Randomized traffic; source holds word while stalled
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         stall = in_valid && !in_ready && !rst;
         @(posedge clk);
         #1;
         rst = ($urandom_range(0, 299) == 0);
         if (!stall) drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom));
         out1_ready = ($urandom_range(0, 2) != 0);
         out2_ready = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'($urandom);
      end
      rst = 1'b0;
      drive(0, 0, '0);
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
